// File: rtl/clock_timer_param.sv
// 24-hour BCD clock: prescaled seconds tick, minute adjust buttons, 12/24h display; alarm option under CLOCK_TIMER_ALARM_EN.
// Latency: a button fall changes the registers on the 3rd rising clk edge; outputs are combinational from registers.
// Backpressure: none; plus and minus in the same cycle cancel, and an adjust beats a same-cycle minute rollover.
module clock_timer_param #(
   parameter int TICK_DIV     = 1,
   parameter int SECS_PER_MIN = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       plus,
   input  logic       minus,
   input  logic       mode_12h,
   input  logic       alarm_sel,
   input  logic       alarm_en,
   output logic [3:0] sec1,
   output logic [3:0] sec2,
   output logic [3:0] min1,
   output logic [3:0] min2,
   output logic [3:0] hr1,
   output logic [3:0] hr2,
   output logic       pm,
   output logic       alarm
);

   typedef struct packed {
      logic [3:0] h2;
      logic [3:0] h1;
      logic [3:0] m2;
      logic [3:0] m1;
   } hm_t;

   localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [3:0]    SEC_LAST1 = 4'((SECS_PER_MIN - 1) % 10);
   localparam logic [3:0]    SEC_LAST2 = 4'((SECS_PER_MIN - 1) / 10);

   // One-minute advance with BCD ripple; 23:59 wraps to 00:00.
   function automatic hm_t hm_inc(input hm_t t);
      hm_t r;
      r = t;
      if (t.m1 != 4'd9) r.m1 = t.m1 + 4'd1;
      else begin
         r.m1 = 4'd0;
         if (t.m2 != 4'd5) r.m2 = t.m2 + 4'd1;
         else begin
            r.m2 = 4'd0;
            if (t.h2 == 4'd2 && t.h1 == 4'd3) begin
               r.h2 = 4'd0;
               r.h1 = 4'd0;
            end else if (t.h1 == 4'd9) begin
               r.h1 = 4'd0;
               r.h2 = t.h2 + 4'd1;
            end else r.h1 = t.h1 + 4'd1;
         end
      end
      return r;
   endfunction

   // Exact inverse of hm_inc; 00:00 wraps to 23:59.
   function automatic hm_t hm_dec(input hm_t t);
      hm_t r;
      r = t;
      if (t.m1 != 4'd0) r.m1 = t.m1 - 4'd1;
      else begin
         r.m1 = 4'd9;
         if (t.m2 != 4'd0) r.m2 = t.m2 - 4'd1;
         else begin
            r.m2 = 4'd5;
            if (t.h2 == 4'd0 && t.h1 == 4'd0) begin
               r.h2 = 4'd2;
               r.h1 = 4'd3;
            end else if (t.h1 == 4'd0) begin
               r.h1 = 4'd9;
               r.h2 = t.h2 - 4'd1;
            end else r.h1 = t.h1 - 4'd1;
         end
      end
      return r;
   endfunction

   // Button pipes: [0] first sync flop, [1] second sync flop, [2] edge-detect history.
   logic [2:0] plus_q, minus_q;
   logic       plus_ev, minus_ev, step_ev, adj_alarm, adj_time;

   // Synchronise the buttons; reset to 1 so a released reset never looks like a fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         plus_q  <= 3'b111;
         minus_q <= 3'b111;
      end else begin
         plus_q  <= {plus_q[1:0], plus};
         minus_q <= {minus_q[1:0], minus};
      end
   end

   assign plus_ev  = plus_q[2] & ~plus_q[1];
   assign minus_ev = minus_q[2] & ~minus_q[1];
   assign step_ev  = plus_ev ^ minus_ev;

`ifdef CLOCK_TIMER_ALARM_EN
   assign adj_alarm = step_ev & alarm_sel;
`else
   logic alarm_inputs_unused;
   assign alarm_inputs_unused = alarm_sel ^ alarm_en;
   assign adj_alarm = 1'b0;
`endif
   assign adj_time = step_ev & ~adj_alarm;

   hm_t           time_q, time_d;
   logic [3:0]    sec1_q, sec2_q, sec1_d, sec2_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          tick;

   assign tick = (pre_q == PRE_LAST);

   // Time next state: an adjust restarts the minute, otherwise the tick advances seconds.
   always_comb begin
      time_d = time_q;
      sec1_d = sec1_q;
      sec2_d = sec2_q;
      pre_d  = pre_q;
      if (adj_time) begin
         time_d = plus_ev ? hm_inc(time_q) : hm_dec(time_q);
         sec1_d = 4'd0;
         sec2_d = 4'd0;
         pre_d  = '0;
      end else if (tick) begin
         pre_d = '0;
         if (sec2_q == SEC_LAST2 && sec1_q == SEC_LAST1) begin
            sec1_d = 4'd0;
            sec2_d = 4'd0;
            time_d = hm_inc(time_q);
         end else if (sec1_q == 4'd9) begin
            sec1_d = 4'd0;
            sec2_d = sec2_q + 4'd1;
         end else sec1_d = sec1_q + 4'd1;
      end else pre_d = pre_q + PW'(1);
   end

   // Time, seconds and prescaler registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         time_q <= '0;
         sec1_q <= 4'd0;
         sec2_q <= 4'd0;
         pre_q  <= '0;
      end else begin
         time_q <= time_d;
         sec1_q <= sec1_d;
         sec2_q <= sec2_d;
         pre_q  <= pre_d;
      end
   end

`ifdef CLOCK_TIMER_ALARM_EN
   hm_t alm_q, alm_d;

   // Alarm next state: steps by the same minute rules while alarm_sel is high.
   always_comb begin
      alm_d = alm_q;
      if (adj_alarm) alm_d = plus_ev ? hm_inc(alm_q) : hm_dec(alm_q);
   end

   // Alarm hour/minute register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) alm_q <= '0;
      else        alm_q <= alm_d;
   end

   // Gated by rst_n so the 00:00 == 00:00 match cannot fire while held in reset.
   assign alarm = rst_n & alarm_en & (alm_q == time_q);
`else
   assign alarm = 1'b0;
`endif

   logic [4:0] hour_bin, disp12;

   assign hour_bin = 5'(time_q.h2) * 5'd10 + 5'(time_q.h1);
   assign pm       = (hour_bin >= 5'd12);

   // 12-hour view: 0 shows as 12, 13..23 as 1..11; internal state is untouched.
   always_comb begin
      disp12 = hour_bin;
      if (hour_bin == 5'd0)      disp12 = 5'd12;
      else if (hour_bin > 5'd12) disp12 = hour_bin - 5'd12;
   end

   // Hour digits for the selected display format.
   always_comb begin
      hr2 = time_q.h2;
      hr1 = time_q.h1;
      if (mode_12h) begin
         if (disp12 >= 5'd10) begin
            hr2 = 4'd1;
            hr1 = 4'(disp12 - 5'd10);
         end else begin
            hr2 = 4'd0;
            hr1 = 4'(disp12);
         end
      end
   end

   assign sec1 = sec1_q;
   assign sec2 = sec2_q;
   assign min1 = time_q.m1;
   assign min2 = time_q.m2;

endmodule

// File: tb/tb_clock_timer_param.sv
// Bench for clock_timer_param with TICK_DIV=1, SECS_PER_MIN=2 (one minute = two clk cycles).
// Reference model keeps time as minute-of-day and second integers; button events are due two edges after a sampled fall.
// Works in both builds; alarm expectations follow CLOCK_TIMER_ALARM_EN.
module tb_clock_timer_param;
   localparam int TD  = 1;
   localparam int SPM = 2;
   localparam int DAY = 1440 * SPM;
`ifdef CLOCK_TIMER_ALARM_EN
   localparam bit HAS_ALARM = 1'b1;
`else
   localparam bit HAS_ALARM = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n, plus, minus, mode_12h, alarm_sel, alarm_en;
   logic [3:0] sec1, sec2, min1, min2, hr1, hr2;
   logic       pm, alarm;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   clock_timer_param #(.TICK_DIV(TD), .SECS_PER_MIN(SPM)) dut (
      .clk(clk), .rst_n(rst_n), .plus(plus), .minus(minus), .mode_12h(mode_12h),
      .alarm_sel(alarm_sel), .alarm_en(alarm_en),
      .sec1(sec1), .sec2(sec2), .min1(min1), .min2(min2), .hr1(hr1), .hr2(hr2),
      .pm(pm), .alarm(alarm)
   );

   // Reference model state
   int m_min = 0, m_sec = 0, m_pre = 0, m_alm = 0, edge_n = 0;
   bit p_last = 1'b1, n_last = 1'b1;
   int p_due[$];
   int n_due[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_min = 0; m_sec = 0; m_pre = 0; m_alm = 0; edge_n = 0;
         p_last = 1'b1; n_last = 1'b1;
         p_due.delete(); n_due.delete();
      end else begin
         bit ep, em, adj_t;
         int step;
         edge_n++;
         ep = (p_due.size() > 0) && (p_due[0] == edge_n);
         em = (n_due.size() > 0) && (n_due[0] == edge_n);
         if (ep) void'(p_due.pop_front());
         if (em) void'(n_due.pop_front());
         if (p_last && !plus)  p_due.push_back(edge_n + 2);
         if (n_last && !minus) n_due.push_back(edge_n + 2);
         p_last = plus;
         n_last = minus;
         step  = (ep == em) ? 0 : (ep ? 1 : -1);
         adj_t = (step != 0) && !(HAS_ALARM && alarm_sel);
         if (step != 0 && !adj_t) m_alm = (m_alm + step + 1440) % 1440;
         if (adj_t) begin
            m_min = (m_min + step + 1440) % 1440;
            m_sec = 0;
            m_pre = 0;
         end else if (m_pre == TD - 1) begin
            m_pre = 0;
            m_sec++;
            if (m_sec == SPM) begin
               m_sec = 0;
               m_min = (m_min + 1) % 1440;
            end
         end else m_pre++;
      end
   end

   function automatic int hour_disp(input int h, input bit m12);
      if (!m12) return h;
      if (h == 0) return 12;
      return (h > 12) ? h - 12 : h;
   endfunction

   function automatic int exp_alarm();
      return (HAS_ALARM && rst_n && alarm_en && (m_alm == m_min)) ? 1 : 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      int h, hd;
      h  = m_min / 60;
      hd = hour_disp(h, mode_12h);
      check({tag, ".sec1"}, sec1, m_sec % 10);
      check({tag, ".sec2"}, sec2, m_sec / 10);
      check({tag, ".min1"}, min1, (m_min % 60) % 10);
      check({tag, ".min2"}, min2, (m_min % 60) / 10);
      check({tag, ".hr1"}, hr1, hd % 10);
      check({tag, ".hr2"}, hr2, hd / 10);
      check({tag, ".pm"}, pm, (h >= 12) ? 1 : 0);
      check({tag, ".alarm"}, alarm, exp_alarm());
   endtask

   task automatic check_hms(input string tag, input int hh, input int mm, input int ss);
      check({tag, ".hr2"}, hr2, hh / 10);
      check({tag, ".hr1"}, hr1, hh % 10);
      check({tag, ".min2"}, min2, mm / 10);
      check({tag, ".min1"}, min1, mm % 10);
      check({tag, ".sec2"}, sec2, ss / 10);
      check({tag, ".sec1"}, sec1, ss % 10);
   endtask

   // Returns at a negedge where the model's cycle-of-day equals target.
   task automatic wait_t(input int target);
      int n;
      n = 0;
      @(negedge clk);
      while ((m_min * SPM + m_sec) != target && n < DAY + 10) begin
         @(negedge clk);
         n++;
      end
      if (n >= DAY + 10) begin
         checks++;
         errors++;
         $error("FAIL wait_t: timeout observed %0d expected %0d", m_min * SPM + m_sec, target);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi;
      rst_n = 1'b0; plus = 1'b1; minus = 1'b1;
      mode_12h = 1'b0; alarm_sel = 1'b0; alarm_en = 1'b1;
      #12;
      check_hms("reset", 0, 0, 0);
      check("reset.pm", pm, 0);
      check("reset.alarm", alarm, 0);
      check_model("reset");

      // Button held low across reset release gives exactly one event
      minus = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); check_hms("hold.e1", 0, 0, 1);
      @(negedge clk); check_hms("hold.e2", 0, 1, 0);
      @(negedge clk); check_hms("hold.e3", 0, 0, 0); check_model("hold.e3");
      repeat (2) @(negedge clk);
      check_hms("hold.e5", 0, 1, 0);
      minus = 1'b1;

      // Single minus landing at 00:00:01 -> 23:59:00 on the third edge
      wait_t(DAY - 1);
      minus = 1'b0;
      @(negedge clk); check_hms("minus.e1", 0, 0, 0);
      @(negedge clk); check_hms("minus.e2", 0, 0, 1);
      @(negedge clk); check_hms("minus.e3", 23, 59, 0); check_model("minus.e3");
      mode_12h = 1'b1; #1;
      check_hms("minus.12h", 11, 59, 0);
      check("minus.12h.pm", pm, 1);
      mode_12h = 1'b0; #1;
      check_hms("minus.24h", 23, 59, 0);
      minus = 1'b1;
      @(negedge clk); check_hms("run.t1", 23, 59, 1);
      @(negedge clk); check_hms("run.t2", 0, 0, 0);
      check("run.t2.pm", pm, 0);
      check_model("run.t2");

      // Plus coincident with the last second of 01:05 -> 01:06:00
      wait_t(65 * SPM - 1);
      plus = 1'b0;
      @(negedge clk);
      @(negedge clk); check_hms("roll.e2", 1, 5, 1);
      @(negedge clk); check_hms("roll.e3", 1, 6, 0); check_model("roll.e3");
      plus = 1'b1;

      // Plus and minus together at 09:59:00 cancel: minute kept, seconds keep running
      wait_t(599 * SPM - 2);
      plus = 1'b0; minus = 1'b0;
      @(negedge clk);
      @(negedge clk); check_hms("cancel.e2", 9, 59, 0);
      @(negedge clk); check_hms("cancel.e3", 9, 59, 1); check_model("cancel.e3");
      plus = 1'b1; minus = 1'b1;

      // Plus alone at 09:59:01 -> 10:00:00
      wait_t(599 * SPM - 1);
      plus = 1'b0;
      @(negedge clk);
      @(negedge clk); check_hms("plus.e2", 9, 59, 1);
      @(negedge clk); check_hms("plus.e3", 10, 0, 0); check_model("plus.e3");
      plus = 1'b1;

      // Set alarm to 00:02 with alarm_sel, then run a full day
      @(negedge clk); alarm_sel = 1'b1;
      repeat (2) begin
         plus = 1'b0;
         repeat (3) @(negedge clk);
         plus = 1'b1;
         @(negedge clk);
      end
      alarm_sel = 1'b0;
      check_model("alarm.set");
      hi = 0;
      repeat (DAY) begin
         @(negedge clk);
         check("day.alarm", alarm, exp_alarm());
         if (alarm === 1'b1) hi++;
      end
      check("day.alarm_cycles", hi, HAS_ALARM ? SPM : 0);

      // alarm_en falling drops the alarm at once
      wait_t(2 * SPM);
      check("alarm.at_0002", alarm, HAS_ALARM ? 1 : 0);
      alarm_en = 1'b0; #1;
      check("alarm.en_off", alarm, 0);
      alarm_en = 1'b1;

      // Asynchronous reset mid-cycle and mid-press at 12:34
      wait_t(754 * SPM + 1);
      check_model("pre_reset");
      @(posedge clk); #2;
      plus = 1'b0; #1;
      rst_n = 1'b0; #1;
      check_hms("areset", 0, 0, 0);
      check("areset.pm", pm, 0);
      check("areset.alarm", alarm, 0);
      check_model("areset");
      @(negedge clk); rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_model("post_reset");
      plus = 1'b1;
      repeat ($urandom_range(3, 9)) @(negedge clk);
      check_model("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/clock_timer_param.md
CLOCK_TIMER_PARAM -- requirements
Module: clock_timer_param

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1: clk cycles per one-second tick (1..2^24).
REQ-002 SHALL have parameter SECS_PER_MIN, default 60: ticks per minute (2..60; smaller values are for simulation speed-up).
REQ-003 SHALL have port clk  in  1  single system clock, rising-edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous reset, active-low.
REQ-005 SHALL have ports plus, minus  in  1 each  asynchronous adjust buttons; a falling edge is one step.
REQ-006 SHALL have port mode_12h  in  1  display format select (1 = 12-hour).
REQ-007 SHALL have port alarm_sel  in  1  while high, buttons adjust the alarm instead of the time.
REQ-008 SHALL have port alarm_en  in  1  alarm arm.
REQ-009 SHALL have ports sec1, sec2, min1, min2, hr1, hr2  out  4 each  BCD display digits (1 = ones, 2 = tens).
REQ-010 SHALL have port pm  out  1  high when internal hour >= 12.
REQ-011 SHALL have port alarm  out  1  alarm active.

Function
REQ-012 SHALL hold time internally as 24-hour BCD, 00:00:00..23:59:(SECS_PER_MIN-1).
REQ-013 SHALL generate a one-cycle tick every TICK_DIV clk cycles from a prescaler; with TICK_DIV=1 the tick is high every cycle.
REQ-014 On each tick, the seconds counter SHALL increment; at SECS_PER_MIN-1 it SHALL wrap to 0 and advance the time by one minute.
REQ-015 A one-minute advance SHALL ripple min1 9->0, min2 5->0, hr1 9->0 (or 3->0 when hr2=2), hr2 2->0; 23:59 -> 00:00.
REQ-016 A one-minute decrement SHALL be the exact inverse; 00:00 -> 23:59, x0:00 -> (x-1)9:59.
REQ-017 Each of plus and minus SHALL pass through a 2-flop synchronizer plus an edge-detect flop; a 1->0 transition SHALL be one event.
REQ-018 The register update SHALL occur on the 3rd rising clk edge after the button input falls; one event SHALL give exactly one step.
REQ-019 Plus and minus events in the same cycle SHALL cancel, with no change.
REQ-020 A time-adjust event SHALL clear the seconds counter and prescaler to 0 and take priority over a same-cycle minute rollover, which SHALL be discarded.
REQ-021 With alarm_sel=1, events SHALL step alarm hours/minutes by the same rules, and the time SHALL keep running.
REQ-022 Outputs SHALL be combinational from the registers; with mode_12h=0, hr digits SHALL equal the internal hour.
REQ-023 With mode_12h=1, hour 0 SHALL display 12, hours 13..23 SHALL display 1..11, and hours 1..12 SHALL display unchanged.
REQ-024 pm SHALL be independent of mode_12h.
REQ-025 Changing mode_12h SHALL never modify internal state.

Reset
REQ-026 While rst_n=0: time 00:00:00, alarm 00:00, prescaler 0, synchronizer flops 1 (no spurious event on release).
REQ-027 While rst_n=0: pm=0, alarm=0.
REQ-028 Reset asserted mid-operation or mid-button-press SHALL clear immediately without waiting for clk.
REQ-029 After reset release, a button held low SHALL produce exactly one event.

Configuration
REQ-030 With macro CLOCK_TIMER_ALARM_EN defined, the alarm registers SHALL exist.
REQ-031 With CLOCK_TIMER_ALARM_EN defined, alarm SHALL be high while alarm_en=1 and hr/min equal the alarm, for that whole minute.
REQ-032 With CLOCK_TIMER_ALARM_EN defined, alarm SHALL deassert within one cycle of alarm_en falling.
REQ-033 Without the macro, the alarm registers SHALL be absent and alarm SHALL be tied 0.
REQ-034 Without the macro, alarm_sel and alarm_en SHALL be ignored and all events SHALL adjust time.
REQ-035 The port list SHALL be identical in both builds.

Verification
REQ-036 Bench SHALL run TICK_DIV=1, SECS_PER_MIN=2, preload 23:59 via minus from reset, then run 2 ticks -> 00:00:00, pm=0.
REQ-037 Bench SHALL apply from reset a single minus press -> 23:59 exactly 3 edges later; mode_12h=1 -> display 11:59, pm=1.
REQ-038 Bench SHALL apply plus and minus falling in the same cycle at 09:59 -> stays 09:59; then plus alone -> 10:00.
REQ-039 Bench SHALL apply a plus event coincident with seconds = SECS_PER_MIN-1 at 01:05 -> 01:06:00, not 01:07.
REQ-040 Bench SHALL (ALARM_EN) set alarm 00:02 via alarm_sel, alarm_en=1, and run -> alarm high for 00:02:00..00:02:59, else low.
REQ-041 Bench SHALL assert rst_n=0 asynchronously mid-tick at 12:34:30 -> all outputs 0 before the next clk edge.
